// File: rtl/stack_mc_pkg.sv
// Shared definitions for the stack-machine core: opcodes, ALU codes, the
// multi-cycle controller state encoding and the control-vector layout.
package stack_mc_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StIf    = 4'd1,
    StId    = 4'd2,
    StPopA  = 4'd3,
    StPopB  = 4'd4,
    StNot1  = 4'd5,
    StPushR = 4'd6,
    StPshM  = 4'd7,
    StPopM  = 4'd8,
    StJmp   = 4'd9,
    StJz    = 4'd10
  } state_t;

  typedef struct packed {
    logic       busy;
    logic       ldpc;
    logic       ldmem;
    logic       ldalu;
    logic       pcsrc;
    logic       memsrc;
    logic       alusrc_a;
    logic       alusrc_b;
    logic       stksrc;
    logic       mem_read;
    logic       mem_write;
    logic       push;
    logic       pop;
    logic       tos;
    logic [1:0] alu_control;
  } ctrl_t;

endpackage

// File: rtl/stack_mc_outdec.sv
// Control-vector decoder for the stack-machine controller.
// Ports:
//   state  - current controller state
//   zero   - stack top equals zero (only used by JZ)
//   alu_op - opcode[1:0], forwarded as the ALU code in POPB
//   ctrl   - full control vector; everything not listed for a state is 0
module stack_mc_outdec
  import stack_mc_pkg::*;
(
  input  state_t     state,
  input  logic       zero,
  input  logic [1:0] alu_op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      StIf: begin
        // PC+1 through the ALU: alusrcA=0 (PC), alusrcB=0 (constant 1)
        ctrl.busy        = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.ldmem       = 1'b1;
        ctrl.ldpc        = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      StId: begin
        ctrl.busy = 1'b1;
        ctrl.tos  = 1'b1;
      end
      StPopA: begin
        ctrl.busy = 1'b1;
        ctrl.tos  = 1'b1;
        ctrl.pop  = 1'b1;
      end
      StPopB: begin
        ctrl.busy        = 1'b1;
        ctrl.tos         = 1'b1;
        ctrl.pop         = 1'b1;
        ctrl.alusrc_a    = 1'b1;
        ctrl.alusrc_b    = 1'b1;
        ctrl.ldalu       = 1'b1;
        ctrl.alu_control = alu_op;
      end
      StNot1: begin
        ctrl.busy        = 1'b1;
        ctrl.tos         = 1'b1;
        ctrl.pop         = 1'b1;
        ctrl.alusrc_a    = 1'b1;
        ctrl.ldalu       = 1'b1;
        ctrl.alu_control = ALU_NOT;
      end
      StPushR: begin
        ctrl.busy = 1'b1;
        ctrl.push = 1'b1;
      end
      StPshM: begin
        ctrl.busy     = 1'b1;
        ctrl.memsrc   = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.stksrc   = 1'b1;
        ctrl.push     = 1'b1;
      end
      StPopM: begin
        ctrl.busy      = 1'b1;
        ctrl.tos       = 1'b1;
        ctrl.memsrc    = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.pop       = 1'b1;
      end
      StJmp: begin
        ctrl.busy  = 1'b1;
        ctrl.pcsrc = 1'b1;
        ctrl.ldpc  = 1'b1;
      end
      StJz: begin
        // Branch taken only when the (unpopped) top is zero
        ctrl.busy  = 1'b1;
        ctrl.tos   = 1'b1;
        ctrl.pcsrc = 1'b1;
        ctrl.ldpc  = zero;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/stack_mc_controller.sv
// Multi-cycle control FSM for the 8-bit stack-machine datapath.
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-high reset
//   start         - leaves IDLE when high (ignored elsewhere)
//   opcode        - IR[7:5] from the datapath
//   d_out         - stack top from the datapath (zero test for JZ)
//   ldpc/ldmem/ldalu                          - register load enables
//   pcsrc/memsrc/alusrcA/alusrcB/stksrc       - mux selects
//   memRead/memWrite, push/pop/tos            - memory and stack strobes
//   alu_control   - 00 ADD, 01 SUB, 10 AND, 11 NOT
//   busy          - high in every state except IDLE
module stack_mc_controller
  import stack_mc_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    opcode,
  input  logic [DW-1:0] d_out,
  output logic          ldpc,
  output logic          ldmem,
  output logic          ldalu,
  output logic          pcsrc,
  output logic          memsrc,
  output logic          alusrcA,
  output logic          alusrcB,
  output logic          stksrc,
  output logic          memRead,
  output logic          memWrite,
  output logic          push,
  output logic          pop,
  output logic          tos,
  output logic [1:0]    alu_control,
  output logic          busy
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   zero;

  assign zero = (d_out == '0);

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:  state_d = start ? StIf : StIdle;
      StIf:    state_d = StId;
      StId: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: state_d = StPopA;
          OP_NOT:                 state_d = StNot1;
          OP_PUSH:                state_d = StPshM;
          OP_POP:                 state_d = StPopM;
          OP_JMP:                 state_d = StJmp;
          OP_JZ:                  state_d = StJz;
          default:                state_d = StIdle;
        endcase
      end
      StPopA:  state_d = StPopB;
      StPopB:  state_d = StPushR;
      StNot1:  state_d = StPushR;
      StPushR: state_d = StIf;
      StPshM:  state_d = StIf;
      StPopM:  state_d = StIf;
      StJmp:   state_d = StIf;
      StJz:    state_d = StIf;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  stack_mc_outdec u_outdec (
    .state  (state_q),
    .zero   (zero),
    .alu_op (opcode[1:0]),
    .ctrl   (ctrl)
  );

  assign busy        = ctrl.busy;
  assign ldpc        = ctrl.ldpc;
  assign ldmem       = ctrl.ldmem;
  assign ldalu       = ctrl.ldalu;
  assign pcsrc       = ctrl.pcsrc;
  assign memsrc      = ctrl.memsrc;
  assign alusrcA     = ctrl.alusrc_a;
  assign alusrcB     = ctrl.alusrc_b;
  assign stksrc      = ctrl.stksrc;
  assign memRead     = ctrl.mem_read;
  assign memWrite    = ctrl.mem_write;
  assign push        = ctrl.push;
  assign pop         = ctrl.pop;
  assign tos         = ctrl.tos;
  assign alu_control = ctrl.alu_control;

endmodule

// File: tb/tb_stack_mc_controller.sv
// Scoreboard bench for stack_mc_controller: stimulus queues the expected
// per-cycle control vector, a negedge monitor pops and compares. A small
// behavioural datapath runs a short program for the co-simulation check.
module tb_stack_mc_controller;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] opcode, op_drv;
  logic [7:0] d_out, dv_drv;
  logic       ldpc, ldmem, ldalu, pcsrc, memsrc, alusrcA, alusrcB, stksrc;
  logic       memRead, memWrite, push, pop, tos, busy;
  logic [1:0] alu_control;

  always #5 clk = ~clk;

  stack_mc_controller #(.DW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .d_out(d_out),
    .ldpc(ldpc), .ldmem(ldmem), .ldalu(ldalu), .pcsrc(pcsrc), .memsrc(memsrc),
    .alusrcA(alusrcA), .alusrcB(alusrcB), .stksrc(stksrc), .memRead(memRead),
    .memWrite(memWrite), .push(push), .pop(pop), .tos(tos),
    .alu_control(alu_control), .busy(busy)
  );

  // Observed vector, bit layout matches the B_* constants below
  logic [15:0] act;
  assign act = {busy, ldpc, ldmem, ldalu, pcsrc, memsrc, alusrcA, alusrcB,
                stksrc, memRead, memWrite, push, pop, tos, alu_control};

  localparam logic [15:0] B_BUSY = 16'h8000, B_LDPC  = 16'h4000, B_LDMEM = 16'h2000;
  localparam logic [15:0] B_LDALU = 16'h1000, B_PCSRC = 16'h0800, B_MEMSRC = 16'h0400;
  localparam logic [15:0] B_ASRCA = 16'h0200, B_ASRCB = 16'h0100, B_STKSRC = 16'h0080;
  localparam logic [15:0] B_MEMRD = 16'h0040, B_MEMWR = 16'h0020, B_PUSH = 16'h0010;
  localparam logic [15:0] B_POP = 16'h0008, B_TOS = 16'h0004;

  localparam logic [15:0] V_IDLE  = 16'h0000;
  localparam logic [15:0] V_IF    = B_BUSY | B_LDPC | B_LDMEM | B_MEMRD;
  localparam logic [15:0] V_ID    = B_BUSY | B_TOS;
  localparam logic [15:0] V_POPA  = B_BUSY | B_TOS | B_POP;
  localparam logic [15:0] V_POPB  = B_BUSY | B_TOS | B_POP | B_ASRCA | B_ASRCB | B_LDALU;
  localparam logic [15:0] V_NOT1  = B_BUSY | B_TOS | B_POP | B_ASRCA | B_LDALU | 16'h0003;
  localparam logic [15:0] V_PUSHR = B_BUSY | B_PUSH;
  localparam logic [15:0] V_PSHM  = B_BUSY | B_MEMSRC | B_MEMRD | B_STKSRC | B_PUSH;
  localparam logic [15:0] V_POPM  = B_BUSY | B_TOS | B_MEMSRC | B_MEMWR | B_POP;
  localparam logic [15:0] V_JMP   = B_BUSY | B_PCSRC | B_LDPC;
  localparam logic [15:0] V_JZT   = B_BUSY | B_TOS | B_PCSRC | B_LDPC;
  localparam logic [15:0] V_JZN   = B_BUSY | B_TOS | B_PCSRC;

  typedef struct {
    logic [15:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural datapath, active only during co-simulation
  logic       cosim;
  logic [4:0] pc;
  logic [7:0] ir, a_q, alu_q, top;
  logic [7:0] mem [32];
  logic [7:0] stack [16];
  int         sp;

  assign top    = (sp > 0) ? stack[sp-1] : 8'h00;
  assign opcode = cosim ? ir[7:5] : op_drv;
  assign d_out  = cosim ? top : dv_drv;

  always @(posedge clk) begin
    if (!cosim) begin
      pc <= 5'd0;
      ir <= 8'h00;
      sp <= 0;
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      mem[0]  <= 8'h94;  // PUSH 20
      mem[1]  <= 8'h95;  // PUSH 21
      mem[2]  <= 8'h20;  // SUB
      mem[3]  <= 8'hB6;  // POP 22
      mem[4]  <= 8'hC0;  // JMP 0
      mem[20] <= 8'h09;
      mem[21] <= 8'h04;
    end else begin
      if (ldmem) ir <= mem[pc];
      if (ldpc) pc <= pcsrc ? ir[4:0] : pc + 5'd1;
      if (ldalu) begin
        case (alu_control)
          2'b00:   alu_q <= top + a_q;
          2'b01:   alu_q <= top - a_q;
          2'b10:   alu_q <= top & a_q;
          default: alu_q <= ~top;
        endcase
      end
      if (pop) begin
        a_q <= top;
        sp  <= sp - 1;
      end
      if (push) begin
        stack[sp] <= stksrc ? mem[ir[4:0]] : alu_q;
        sp        <= sp + 1;
      end
      if (memWrite) mem[ir[4:0]] <= top;
    end
  end

  // Monitor: one queued expectation per cycle, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.v);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic exp_push(input logic [15:0] v, input string name);
    exp_t e;
    e.v    = v;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset, then start one instruction; returns #1 after the edge into IF
  task automatic issue(input logic [2:0] op, input logic [7:0] dv, input logic co);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    op_drv = op;
    dv_drv = dv;
    cosim  = co;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_drv = 3'b000; dv_drv = 8'h00; cosim = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Async reset in the middle of POPB, then IDLE must hold with start low
    issue(3'b000, 8'h00, 1'b0);
    exp_push(V_IF, "rst_if");
    exp_push(V_ID, "rst_id");
    exp_push(V_POPA, "rst_popa");
    exp_push(V_POPB, "rst_popb");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("reset_mid_popb", {16'h0, act}, {16'h0, V_IDLE});
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) exp_push(V_IDLE, "idle_hold");
    wait_n(5);

    // ADD / SUB / AND: 5 cycles then refetch
    for (int k = 0; k < 3; k++) begin
      logic [2:0] op;
      op = 3'(k);
      issue(op, 8'h00, 1'b0);
      exp_push(V_IF, "alu_if");
      exp_push(V_ID, "alu_id");
      exp_push(V_POPA, "alu_popa");
      exp_push(V_POPB | {14'h0, op[1:0]}, "alu_popb");
      exp_push(V_PUSHR, "alu_pushr");
      exp_push(V_IF, "alu_next_if");
      wait_n(6);
    end

    // NOT: 4 cycles, start held high to show it is ignored when busy
    issue(3'b011, 8'h00, 1'b0);
    start = 1'b1;
    exp_push(V_IF, "not_if");
    exp_push(V_ID, "not_id");
    exp_push(V_NOT1, "not_not1");
    exp_push(V_PUSHR, "not_pushr");
    exp_push(V_IF, "not_next_if");
    wait_n(5);
    start = 1'b0;

    issue(3'b100, 8'h00, 1'b0);
    exp_push(V_IF, "push_if");
    exp_push(V_ID, "push_id");
    exp_push(V_PSHM, "push_pshm");
    exp_push(V_IF, "push_next_if");
    wait_n(4);

    issue(3'b101, 8'h00, 1'b0);
    exp_push(V_IF, "pop_if");
    exp_push(V_ID, "pop_id");
    exp_push(V_POPM, "pop_popm");
    exp_push(V_IF, "pop_next_if");
    wait_n(4);

    issue(3'b110, 8'h00, 1'b0);
    exp_push(V_IF, "jmp_if");
    exp_push(V_ID, "jmp_id");
    exp_push(V_JMP, "jmp_jmp");
    exp_push(V_IF, "jmp_next_if");
    wait_n(4);

    issue(3'b111, 8'h00, 1'b0);
    exp_push(V_IF, "jz0_if");
    exp_push(V_ID, "jz0_id");
    exp_push(V_JZT, "jz0_taken");
    exp_push(V_IF, "jz0_next_if");
    wait_n(4);

    issue(3'b111, 8'h05, 1'b0);
    exp_push(V_IF, "jz5_if");
    exp_push(V_ID, "jz5_id");
    exp_push(V_JZN, "jz5_not_taken");
    exp_push(V_IF, "jz5_next_if");
    wait_n(4);

    // Co-simulation: PUSH 20, PUSH 21, SUB, POP 22, JMP 0
    issue(3'b000, 8'h00, 1'b1);
    wait_n(14);
    check("cosim_mem22", {24'h0, mem[22]}, 32'h5);
    check("cosim_sp", sp, 32'h0);
    wait_n(3);
    check("cosim_jmp_pc", {27'h0, pc}, 32'h0);
    check("cosim_refetch_if", {16'h0, act}, {16'h0, V_IF});
    wait_n(1);
    check("cosim_refetch_ir", {24'h0, ir}, 32'h94);
    cosim = 1'b0;

    check("queue_drained", q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_mc_controller.md
Name: stack_mc_controller

Overview:
- Multi-cycle control FSM for the 8-bit stack-machine datapath (5-bit PC, instruction register, hardware stack, A register, ALU register).
- Takes the 3-bit opcode from the instruction register and the stack top from d_out.
- Drives every load, mux-select, memory and stack strobe, one microstep per clock.
- Adds start/busy handshake so the testbench or top level can hold the core idle after reset.

Parameters:
- DW, 8, data/stack width (width of d_out; used only for the zero test).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  leaves IDLE when high
- opcode  in  3  IR[7:5] from datapath
- d_out  in  DW  stack top from datapath
- ldpc, ldmem, ldalu  out  1 each  register load enables
- pcsrc, memsrc, alusrcA, alusrcB, stksrc  out  1 each  mux selects (1 = IR/stack/A/memory path)
- memRead, memWrite  out  1 each  memory strobes
- push, pop, tos  out  1 each  stack controls
- alu_control  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT (ALU out = stack_out op A, or NOT stack_out)
- busy  out  1  high in every state except IDLE

Behaviour:
- ISA: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH addr, 101 POP addr, 110 JMP addr, 111 JZ addr (addr = IR[4:0]).
- Moore outputs decoded from state; the only exception is JZ's ldpc, which also depends on zero = (d_out == 0).
- Any output not listed for a state is 0, including unused selects.
- Reset: state = IDLE, all outputs 0; asynchronous, effective mid-instruction. Datapath reset is separate.

States and asserted outputs:
- IDLE: nothing asserted. start=1 -> IF, else stay.
- IF: memRead, ldmem, ldpc, alu_control=00 (PC+1 via alusrcA=0, alusrcB=0). -> ID.
- ID: tos. Dispatch on opcode:
  - 000/001/010 -> POPA
  - 011 -> NOT1
  - 100 -> PSHM
  - 101 -> POPM
  - 110 -> JMP
  - 111 -> JZ
- POPA: tos, pop. A captures the old top at this edge. -> POPB.
- POPB: tos, pop, alusrcA, alusrcB, ldalu, alu_control=opcode[1:0]. Result = second op top; SUB is second minus top. -> PUSHR.
- NOT1: tos, pop, alusrcA, ldalu, alu_control=11. -> PUSHR.
- PUSHR: push, stksrc=0 (ALU register to stack). -> IF.
- PSHM: memsrc, memRead, stksrc, push. Memory read is combinational in the same cycle. -> IF.
- POPM: tos, memsrc, memWrite, pop. memWrite is high for exactly one cycle. -> IF.
- JMP: pcsrc, ldpc. -> IF.
- JZ: tos, pcsrc; ldpc = zero. JZ does not pop. -> IF.

Cycle counts per instruction:
- ADD/SUB/AND: 5
- NOT: 4
- PUSH/POP/JMP/JZ: 3

Boundary and error conditions:
- start is ignored outside IDLE; the core never returns to IDLE except via rst.
- push and pop are never high together. memRead and memWrite are never high together.
- Stack underflow/overflow is not detected here; it is the datapath's responsibility.
- Illegal state encodings -> IDLE with all outputs 0.
- PC wraps 31 -> 0 naturally via the 5-bit register.

Decomposition:
- Shared package holds opcode constants (OP_ADD..OP_JZ), ALU codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_NOT) and the 4-bit state encoding. The datapath ALU uses the same package.
- One sub-module, stack_mc_outdec: combinational state+zero -> control-vector decoder.
- Top keeps only the state register and next-state logic.

Test Plan:
- Reset asserted mid-POPB -> all outputs 0 immediately, busy=0. After release with start=0 for 5 cycles -> stays IDLE.
- start pulse, opcode=000 -> state trace IF,ID,POPA,POPB,PUSHR,IF. In POPB alu_control=00 with ldalu, alusrcA, alusrcB =1. pop high in exactly 2 cycles, push in 1.
- opcode=001 and opcode=011 -> POPB shows alu_control=01 (5-cycle sequence). NOT1 shows alu_control=11, alusrcB=0 (4-cycle sequence).
- opcode=100 -> PSHM asserts memsrc, memRead, stksrc, push together for one cycle. opcode=101 -> POPM asserts memWrite and pop for exactly one cycle with memRead=0.
- opcode=111 with d_out=8'h00 -> ldpc=1 and pcsrc=1 in JZ. With d_out=8'h05 -> ldpc=0 and pop=0.
- Co-sim with datapath, program PUSH 20, PUSH 21, SUB, POP 22, mem[20]=9, mem[21]=4 -> mem[22]=5 after 14 cycles from start. JMP 0 then refetches address 0.
